// File: rtl/sparse_filter.sv
// sparse_filter: mask-driven compaction of activation/weight lane pairs with valid/ready handshakes.
// Optional SPARSE_FILTER_ZERO_SKIP_EN ends a job early once no emit bits remain.
module sparse_filter #(
  parameter int IL = 4,
  parameter int FL = 16,
  parameter int N  = 16,
  parameter int L  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*(IL+FL)-1:0]   i_data,
  input  logic [N*(IL+FL)-1:0]   w_data,
  input  logic [L-1:0]           o_mask,
  input  logic [L-1:0]           xor_i_mask,
  input  logic [L-1:0]           xor_w_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*(IL+FL)-1:0]   oi_data,
  output logic [N*(IL+FL)-1:0]   ow_data,
  output logic [$clog2(N+1)-1:0] o_count,
  output logic                   overflow
);
  localparam int W  = IL + FL;
  localparam int CW = $clog2(N + 1);
  localparam int MW = $clog2(L);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t r_st, w_nxt;

  logic [N*W-1:0] r_i, r_w, r_oi, r_ow;
  logic [L-1:0]   r_om, r_xi, r_xw;
  logic [MW-1:0]  r_m;
  logic [CW-1:0]  r_ip, r_wp, r_cnt;
  logic           r_ovf;
  logic           w_bit, w_last, w_skip, w_emit;
  logic [CW-1:0]  w_ip_n, w_wp_n;

  assign w_bit  = r_om[r_m];
  assign w_last = r_m == MW'(L - 1);
`ifdef SPARSE_FILTER_ZERO_SKIP_EN
  assign w_skip = (r_om >> r_m) == '0;
`else
  assign w_skip = 1'b0;
`endif
  assign w_emit = w_bit && r_ip < CW'(N) && r_wp < CW'(N) && r_cnt < CW'(N);
  // A set emit bit consumes a lane from both operands even when the slot is dropped.
  assign w_ip_n = ((w_bit || r_xi[r_m]) && r_ip != CW'(N)) ? r_ip + 1'b1 : r_ip;
  assign w_wp_n = ((w_bit || r_xw[r_m]) && r_wp != CW'(N)) ? r_wp + 1'b1 : r_wp;

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_st <= IDLE;
    else        r_st <= w_nxt;

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE:    w_nxt = in_valid ? COMPUTE : IDLE;
      COMPUTE: w_nxt = (w_skip || w_last) ? DONE : COMPUTE;
      DONE:    w_nxt = out_ready ? IDLE : DONE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i   <= '0;
      r_w   <= '0;
      r_om  <= '0;
      r_xi  <= '0;
      r_xw  <= '0;
      r_m   <= '0;
      r_ip  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_oi  <= '0;
      r_ow  <= '0;
    end else if (r_st == IDLE && in_valid) begin
      r_i   <= i_data;
      r_w   <= w_data;
      r_om  <= o_mask;
      r_xi  <= xor_i_mask;
      r_xw  <= xor_w_mask;
      r_m   <= '0;
      r_ip  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_oi  <= '0;
      r_ow  <= '0;
    end else if (r_st == COMPUTE && !w_skip) begin
      if (w_emit) begin
        r_oi[r_cnt*W +: W] <= r_i[r_ip*W +: W];
        r_ow[r_cnt*W +: W] <= r_w[r_wp*W +: W];
        r_cnt              <= r_cnt + 1'b1;
      end else if (w_bit) begin
        r_ovf <= 1'b1;
      end
      r_ip <= w_ip_n;
      r_wp <= w_wp_n;
      r_m  <= w_last ? r_m : r_m + 1'b1;
    end
  end

  assign in_ready  = r_st == IDLE;
  assign out_valid = r_st == DONE;
  assign oi_data   = r_oi;
  assign ow_data   = r_ow;
  assign o_count   = r_cnt;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_sparse_filter.sv
// tb_sparse_filter: directed self-checking bench for sparse_filter (default N=16, L=32).
module tb_sparse_filter;
  localparam int IL = 4, FL = 16, N = 16, L = 32, W = IL + FL, CW = $clog2(N + 1);
`ifdef SPARSE_FILTER_ZERO_SKIP_EN
  localparam bit SK = 1'b1;
`else
  localparam bit SK = 1'b0;
`endif

  logic           clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [N*W-1:0] i_data, w_data, di, dw, ei, ew;
  logic [L-1:0]   o_mask = '0, xor_i_mask = '0, xor_w_mask = '0;
  logic           in_ready, out_valid, overflow;
  logic [N*W-1:0] oi_data, ow_data;
  logic [CW-1:0]  o_count;
  int n = 0, fails = 0;

  sparse_filter #(.IL(IL), .FL(FL), .N(N), .L(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .i_data(i_data), .w_data(w_data), .o_mask(o_mask),
    .xor_i_mask(xor_i_mask), .xor_w_mask(xor_w_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .oi_data(oi_data), .ow_data(ow_data), .o_count(o_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [N*W-1:0] o, input logic [N*W-1:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", t, o, e);
    end
  endtask

  task automatic run(input logic [L-1:0] om, input logic [L-1:0] xi, input logic [L-1:0] xw, input int lat);
    int cyc;
    o_mask = om; xor_i_mask = xi; xor_w_mask = xw; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    chk("accept_ready_low", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1 cyc++;
    end
    chk("latency", cyc, lat);
  endtask

  task automatic res(input string t, input logic [N*W-1:0] a, input logic [N*W-1:0] b, input int c, input bit ov);
    chk({t, "_oi"}, oi_data, a);
    chk({t, "_ow"}, ow_data, b);
    chk({t, "_count"}, o_count, c);
    chk({t, "_ovf"}, overflow, ov);
  endtask

  task automatic hs();
    out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("hs_in_ready", in_ready, 1);
    chk("hs_out_valid", out_valid, 0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      di[k*W +: W] = W'(k + 1);
      dw[k*W +: W] = W'(32'h100 + k);
    end
    i_data = di; w_data = dw;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    res("rst", '0, '0, 0, 0);
    reset = 1;
    @(posedge clk); #1;

    // reset in the middle of a job, m = 10
    o_mask = '1; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #1 chk("mid_count", o_count, 10);
    reset = 0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    res("midrst", '0, '0, 0, 0);
    #2 reset = 1;
    @(posedge clk); #1;

    ei = '0; ew = '0;
    for (int s = 0; s < 4; s++) begin
      ei[s*W +: W] = W'(s + 1);
      ew[s*W +: W] = W'(32'h100 + s);
    end
    run(32'h0000000F, '0, '0, SK ? 5 : 32);
    res("basic", ei, ew, 4, 0);
    hs();

    ei = '0; ew = '0;
    ei[0 +: W] = W'(2); ew[0 +: W] = W'(32'h100);
    ei[W +: W] = W'(3); ew[W +: W] = W'(32'h102);
    run(32'h0000000A, 32'h1, 32'h4, SK ? 5 : 32);
    res("ptrskip", ei, ew, 2, 0);
    hs();

    run('1, '0, '0, 32);
    res("ovf", di, dw, 16, 1);
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid; i_data = ~i_data; w_data = w_data ^ {N*W{1'b1}}; o_mask = ~o_mask;
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_oi", oi_data, di);
    end
    i_data = di; w_data = dw; in_valid = 1; out_ready = 1;
    @(posedge clk); #1 out_ready = 0; in_valid = 0;
    chk("hs2_in_ready", in_ready, 1);
    chk("hs2_out_valid", out_valid, 0);
    res("retain", di, dw, 16, 1);
    @(posedge clk); #1;
    chk("no_accept_on_hs", in_ready, 1);

    run('0, '0, '0, SK ? 1 : 32);
    res("zero", '0, '0, 0, 0);
    hs();

    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/sparse_filter.md
# sparse_filter

Parametrised successor to the fixed 16-lane sparsity filter. It accepts one vector of N activation lanes and N weight lanes plus three L-bit sparsity masks. It walks the masks one bit per cycle and emits only the surviving activation/weight pairs, compacted into output slots 0..count-1. It sits between the activation/weight buffers and the MAC lanes, and adds valid/ready handshakes, a pair count, an overflow flag and optional zero-tail skipping.

## Interface
Parameters:
- IL, 4, integer bits per element
- FL, 16, fraction bits per element; element width W = IL+FL, signed
- N, 16, lanes per operand (N ≥ 1)
- L, 32, mask length in bits (L ≥ 2)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  input vector and masks valid
- in_ready  output  1  block can accept input; high only in IDLE
- i_data  input  N*W  activation lanes; lane k at [k*W +: W]
- w_data  input  N*W  weight lanes; same packing
- o_mask  input  L  1 = emit pair at this position
- xor_i_mask  input  L  1 = skip one activation lane (used only where o_mask = 0)
- xor_w_mask  input  L  1 = skip one weight lane (used only where o_mask = 0)
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer takes result
- oi_data  output  N*W  compacted activations; slot s at [s*W +: W]
- ow_data  output  N*W  compacted weights; same packing
- o_count  output  $clog2(N+1)  number of valid slots
- overflow  output  1  at least one emit was dropped

## Operation
- States: IDLE → COMPUTE → DONE → IDLE.
- IDLE: in_ready = 1. On in_valid the block latches i_data, w_data and the three masks. It clears oi_data, ow_data, o_count and overflow to 0, sets m = 0, i_ptr = 0, w_ptr = 0, and goes to COMPUTE.
- COMPUTE, position m:
  - If o_mask[m] = 1 and i_ptr < N, w_ptr < N and o_count < N: write slot[o_count] with activation lane i_ptr and weight lane w_ptr, then increment o_count, i_ptr and w_ptr.
  - If o_mask[m] = 1 and any of those bounds fails: set overflow = 1 and write no slot. i_ptr and w_ptr still increment, saturating at N.
  - If o_mask[m] = 0: i_ptr += xor_i_mask[m] and w_ptr += xor_w_mask[m], each saturating at N.
  - o_mask wins over the xor masks at the same position.
- After position L-1 is processed: go to DONE. m is $clog2(L) bits and never wraps within a job.
- DONE: out_valid = 1 and outputs are stable. On out_ready, go to IDLE.
- Outputs hold their values after the handoff until the next acceptance clears them.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- The block does not accept a new input on the same edge as the output handoff.
- Unwritten slots read 0. The result depends only on the latched copies, so input changes after acceptance have no effect.
- Reset asserted: immediately go to IDLE and clear every register, including mid-COMPUTE or in DONE. Reset values: in_ready = 1, out_valid = 0, oi_data = 0, ow_data = 0, o_count = 0, overflow = 0.

## Timing
- Acceptance happens at edge E0. Without skipping, position m is processed at edge E(m+1).
- DONE is entered at edge EL, and out_valid is high from EL until the handshake edge.
- Handshake at edge Eh puts the block in IDLE with in_ready = 1 after Eh.
- Minimum period per job is L+2 cycles (no skip).
- in_ready and out_valid are decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- SPARSE_FILTER_ZERO_SKIP_EN defined:
  - In COMPUTE at position m, if o_mask[L-1:m] == 0, the next edge goes straight to DONE without processing position m.
  - All-zero o_mask: DONE at E1.
  - Last set bit at position p: DONE at E(p+2).
  - Results are identical to the non-skip build.
- Not defined: all L positions are always processed, and DONE is always at EL.

## Test plan
- Reset mid-job: pull reset low during COMPUTE at m = 10 → out_valid = 0, in_ready = 1, all data, o_count and overflow = 0 without waiting for a clock edge. After release, a new job completes normally.
- Basic emit: i lane k = k+1, w lane k = 0x100+k, o_mask = 0x0000000F, xor masks = 0 → o_count = 4, oi slots 0..3 = 1..4, ow slots 0..3 = 0x100..0x103, slots 4..15 = 0, overflow = 0. DONE at E32 (E5 with skip).
- Pointer skip: o_mask bits {1,3}, xor_i_mask bit 0, xor_w_mask bit 2 → slot0 = (i1, w0), slot1 = (i2, w2), o_count = 2.
- Overflow: o_mask = 0xFFFFFFFF → o_count = 16, slot s = (i_s, w_s), overflow = 1, DONE at E32 in both builds.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE while toggling in_valid and inputs → outputs stable, in_ready = 0, nothing accepted. Then pulse out_ready → IDLE next edge, outputs retained.
- Zero mask: o_mask = 0 → o_count = 0 and all slots = 0. out_valid at E1 with SPARSE_FILTER_ZERO_SKIP_EN, at E32 without.
